// File: rtl/prio_pkg.sv
// rtl/prio_pkg.sv - shared FSM states and mode constants for the priority arbiter
package prio_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

endpackage

// File: rtl/prio_pick.sv
// rtl/prio_pick.sv - combinational rotating downward search over the request lines
module prio_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    input  logic         rr,
    output logic [W-1:0] idx,
    output logic         found
);

    always_comb begin
        int s;
        int c;
        idx   = '0;
        found = 1'b0;
        // Out-of-range start (non-power-of-two N) falls back to the top index.
        s = (rr && (int'(start) < N)) ? int'(start) : N - 1;
        // Walk farthest-first so the candidate nearest to start is written last and wins.
        for (int k = N - 1; k >= 0; k--) begin
            c = (s - k + N) % N;
            if (req[c]) begin
                idx   = W'(c);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_arbiter.sv
// rtl/prio_arbiter.sv - N-way fixed/round-robin arbiter with registered grant held under valid/ready
module prio_arbiter
    import prio_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = $clog2(N),
    parameter int RR = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         ready,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic         valid
);

    localparam logic [W-1:0] PTR_LAST = W'(N - 1);
    localparam logic         RR_EN    = (RR == MODE_RR);

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   ptr;
    logic [W-1:0]   next_ptr;
    logic [W-1:0]   pick_idx;
    logic           pick_found;
    logic           xfer;
    logic           load;

    assign valid = (state == HOLD);
    assign xfer  = valid && ready;

    // The search for a back-to-back load starts from the pointer as it will be after this transfer.
    always_comb begin
        next_ptr = ptr;
        if (xfer) begin
            next_ptr = (out_idx == '0) ? PTR_LAST : out_idx - W'(1);
        end
    end

    prio_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .req   (req),
        .start (next_ptr),
        .rr    (RR_EN),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    load      = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (ready) begin
                    if (pick_found) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            out_idx    <= '0;
            out_onehot <= '0;
            ptr        <= PTR_LAST;
        end else begin
            state <= state_nxt;
            ptr   <= next_ptr;
            if (load) begin
                out_idx    <= pick_idx;
                out_onehot <= N'(1) << pick_idx;
            end else if (state_nxt == IDLE) begin
                out_onehot <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prio_arbiter.sv
// tb/tb_prio_arbiter.sv - scoreboard bench for fixed and round-robin arbiter instances
module tb_prio_arbiter;

    typedef struct {
        logic       v;
        logic [1:0] idx;
        logic [3:0] oh;
    } exp_t;

    typedef struct {
        logic [3:0] rq;
        logic       rdy;
        logic       v;
        logic [1:0] idx;
    } step_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req0 = '0;
    logic       ready0 = 1'b0;
    logic [1:0] out_idx0;
    logic [3:0] out_onehot0;
    logic       valid0;
    logic [3:0] req1 = '0;
    logic       ready1 = 1'b0;
    logic [1:0] out_idx1;
    logic [3:0] out_onehot1;
    logic       valid1;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    exp_t e;

    always #5 clk = ~clk;

    prio_arbiter #(.N(4), .RR(0)) dut_fixed (
        .clk        (clk),
        .rst        (rst),
        .req        (req0),
        .ready      (ready0),
        .out_idx    (out_idx0),
        .out_onehot (out_onehot0),
        .valid      (valid0)
    );

    prio_arbiter #(.N(4), .RR(1)) dut_rr (
        .clk        (clk),
        .rst        (rst),
        .req        (req1),
        .ready      (ready1),
        .out_idx    (out_idx1),
        .out_onehot (out_onehot1),
        .valid      (valid1)
    );

    function automatic exp_t mk(logic v, logic [1:0] idx);
        exp_t r;
        r.v   = v;
        r.idx = idx;
        r.oh  = v ? (4'b0001 << idx) : 4'b0000;
        return r;
    endfunction

    function automatic logic [1:0] highest(logic [3:0] r);
        logic [1:0] h = 2'd0;
        for (int b = 0; b < 4; b++) if (r[b]) h = 2'(b);
        return h;
    endfunction

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        total++;
        if (valid0 !== 1'b0 || out_idx0 !== 2'd0 || out_onehot0 !== 4'b0000) begin
            bad++;
            $display("FAIL reset_fixed got v=%b idx=%0d oh=%b want v=0 idx=0 oh=0000", valid0, out_idx0, out_onehot0);
        end
        total++;
        if (valid1 !== 1'b0 || out_idx1 !== 2'd0 || out_onehot1 !== 4'b0000) begin
            bad++;
            $display("FAIL reset_rr got v=%b idx=%0d oh=%b want v=0 idx=0 oh=0000", valid1, out_idx1, out_onehot1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_fixed_basic();
        step_t t[4] = '{'{4'b0000, 1'b1, 1'b0, 2'd0}, '{4'b0000, 1'b1, 1'b0, 2'd0},
                        '{4'b1010, 1'b1, 1'b1, 2'd3}, '{4'b0000, 1'b1, 1'b0, 2'd0}};
        for (int k = 0; k < 4; k++) begin
            req0 = t[k].rq; ready0 = t[k].rdy;
            q.push_back(mk(t[k].v, t[k].idx));
            @(posedge clk); #1;
            e = q.pop_front();
            total++;
            if (valid0 !== e.v || (e.v && out_idx0 !== e.idx) || out_onehot0 !== e.oh) begin
                bad++;
                $display("FAIL fixed_basic[%0d] got v=%b idx=%0d oh=%b want v=%b idx=%0d oh=%b",
                         k, valid0, out_idx0, out_onehot0, e.v, e.idx, e.oh);
            end
        end
    endtask

    task automatic test_fixed_sweep();
        for (int r = 1; r <= 16; r++) begin
            req0   = (r == 16) ? 4'b0000 : 4'(r);
            ready0 = 1'b1;
            q.push_back(mk(r != 16, highest(req0)));
            @(posedge clk); #1;
            e = q.pop_front();
            total++;
            if (valid0 !== e.v || (e.v && out_idx0 !== e.idx) || out_onehot0 !== e.oh) begin
                bad++;
                $display("FAIL fixed_sweep[req=%b] got v=%b idx=%0d oh=%b want v=%b idx=%0d oh=%b",
                         req0, valid0, out_idx0, out_onehot0, e.v, e.idx, e.oh);
            end
        end
    endtask

    task automatic test_rr_table(string name, int n, step_t t[8]);
        for (int k = 0; k < n; k++) begin
            req1 = t[k].rq; ready1 = t[k].rdy;
            q.push_back(mk(t[k].v, t[k].idx));
            @(posedge clk); #1;
            e = q.pop_front();
            total++;
            if (valid1 !== e.v || (e.v && out_idx1 !== e.idx) || out_onehot1 !== e.oh) begin
                bad++;
                $display("FAIL %s[%0d] got v=%b idx=%0d oh=%b want v=%b idx=%0d oh=%b",
                         name, k, valid1, out_idx1, out_onehot1, e.v, e.idx, e.oh);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t t[8] = '{'{4'b1111, 1'b1, 1'b1, 2'd3}, '{4'b1111, 1'b1, 1'b1, 2'd2},
                        '{4'b1111, 1'b1, 1'b1, 2'd1}, '{4'b1111, 1'b1, 1'b1, 2'd0},
                        '{4'b1111, 1'b1, 1'b1, 2'd3}, '{4'b1111, 1'b1, 1'b1, 2'd2},
                        '{4'b0000, 1'b1, 1'b0, 2'd0}, '{4'b0000, 1'b1, 1'b0, 2'd0}};
        test_rr_table("rr_b2b", 8, t);
    endtask

    task automatic test_hold();
        // ptr is 1 here, so 0101 grants 0 first.
        step_t t[8] = '{'{4'b0101, 1'b0, 1'b1, 2'd0}, '{4'b1010, 1'b0, 1'b1, 2'd0},
                        '{4'b0101, 1'b0, 1'b1, 2'd0}, '{4'b1010, 1'b0, 1'b1, 2'd0},
                        '{4'b0101, 1'b0, 1'b1, 2'd0}, '{4'b1010, 1'b0, 1'b1, 2'd0},
                        '{4'b1010, 1'b1, 1'b1, 2'd3}, '{4'b0000, 1'b1, 1'b0, 2'd0}};
        test_rr_table("rr_hold", 8, t);
    endtask

    task automatic test_idle_return();
        step_t t[8] = '{'{4'b0100, 1'b0, 1'b1, 2'd2}, '{4'b0000, 1'b1, 1'b0, 2'd0},
                        '{4'b0101, 1'b1, 1'b1, 2'd0}, '{4'b0000, 1'b1, 1'b0, 2'd0},
                        '{4'b0000, 1'b1, 1'b0, 2'd0}, '{4'b0000, 1'b1, 1'b0, 2'd0},
                        '{4'b0000, 1'b1, 1'b0, 2'd0}, '{4'b0000, 1'b1, 1'b0, 2'd0}};
        test_rr_table("rr_idle", 4, t);
    endtask

    task automatic test_async_reset();
        step_t t[8] = '{'{4'b1111, 1'b1, 1'b1, 2'd3}, '{4'b1111, 1'b1, 1'b1, 2'd2},
                        '{4'b1111, 1'b0, 1'b1, 2'd2}, '{4'b0000, 1'b0, 1'b0, 2'd0},
                        '{4'b0000, 1'b0, 1'b0, 2'd0}, '{4'b0000, 1'b0, 1'b0, 2'd0},
                        '{4'b0000, 1'b0, 1'b0, 2'd0}, '{4'b0000, 1'b0, 1'b0, 2'd0}};
        test_rr_table("rr_prereset", 3, t);
        #3 rst = 1'b1;
        #1;
        total++;
        if (valid1 !== 1'b0 || out_idx1 !== 2'd0 || out_onehot1 !== 4'b0000) begin
            bad++;
            $display("FAIL async_reset got v=%b idx=%0d oh=%b want v=0 idx=0 oh=0000", valid1, out_idx1, out_onehot1);
        end
        #2 rst = 1'b0;
        req1 = 4'b1111; ready1 = 1'b1;
        q.push_back(mk(1'b1, 2'd3));
        @(posedge clk); #1;
        e = q.pop_front();
        total++;
        if (valid1 !== e.v || out_idx1 !== e.idx || out_onehot1 !== e.oh) begin
            bad++;
            $display("FAIL post_reset_grant got v=%b idx=%0d oh=%b want v=%b idx=%0d oh=%b",
                     valid1, out_idx1, out_onehot1, e.v, e.idx, e.oh);
        end
    endtask

    initial begin
        test_reset();
        test_fixed_basic();
        test_fixed_sweep();
        test_back_to_back();
        test_hold();
        test_idle_return();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
